// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the alu_muldiv execute-stage ALU.
//   alu_op_t           5-bit operation code
//   alu_state_e        control FSM state, also exported for debug
//   is_iter/is_div     opcode classification
//   op1_signed/op2_signed  which operands are treated as two's complement
//   ALU_ILLEGAL_RESULT fill bit for the result of an unknown opcode
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'h00,
      OP_SUB    = 5'h01,
      OP_XOR    = 5'h02,
      OP_OR     = 5'h03,
      OP_AND    = 5'h04,
      OP_SLT    = 5'h05,
      OP_SLTU   = 5'h06,
      OP_SLL    = 5'h07,
      OP_SRL    = 5'h08,
      OP_SRA    = 5'h09,
      OP_MUL    = 5'h0A,
      OP_MULH   = 5'h0B,
      OP_MULHSU = 5'h0C,
      OP_MULHU  = 5'h0D,
      OP_DIV    = 5'h0E,
      OP_DIVU   = 5'h0F,
      OP_REM    = 5'h10,
      OP_REMU   = 5'h11
   } alu_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } alu_state_e;

   localparam logic ALU_ILLEGAL_RESULT = '0;

   function automatic logic is_iter(input alu_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                        OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_div(input alu_op_t op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic op1_signed(input alu_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op2_signed(input alu_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bus of the alu_muldiv execute-stage ALU.
//   request : in_valid, in_ready, ALUctrl, ALUop1, ALUop2
//   response: out_valid, out_ready, ALUresult, EQ, LT, LTU
//   status  : busy, state_dbg (control FSM state)
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload stable until that edge; ready may
// depend on state but never on the valid of the same channel.
interface alu_muldiv_if
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [4:0]            ALUctrl;
   logic [DATA_WIDTH-1:0] ALUop1;
   logic [DATA_WIDTH-1:0] ALUop2;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] ALUresult;
   logic                  EQ;
   logic                  LT;
   logic                  LTU;
   logic                  busy;
   alu_state_e            state_dbg;

   modport master (
      output in_valid, ALUctrl, ALUop1, ALUop2, out_ready,
      input  in_ready, out_valid, ALUresult, EQ, LT, LTU, busy, state_dbg
   );

   modport slave (
      input  in_valid, ALUctrl, ALUop1, ALUop2, out_ready,
      output in_ready, out_valid, ALUresult, EQ, LT, LTU, busy, state_dbg
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: bit-serial multiply / restoring divide on magnitudes.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands and begin DATA_WIDTH iteration steps
//   op       : MUL*/DIV*/REM* opcode, op1/op2 operands (sampled on start)
//   done     : high during the last step; result is valid in that cycle
//   result   : sign-corrected result of the last step (combinational)
// hi/lo form one 2*DATA_WIDTH register: for multiply hi accumulates the
// partial product while lo shifts the multiplier out; for divide hi is the
// partial remainder while lo shifts the dividend out and the quotient in.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  alu_op_t               op,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic             act_q, act_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   alu_op_t          op_q, op_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, b_q, b_d;

   logic             neg1, neg2;
   logic [W-1:0]     mag1, mag2;
   logic [W:0]       sum, shifted, diff;
   logic             ge;
   logic [W-1:0]     hi_n, lo_n;
   logic [2*W-1:0]   prod;

   // Operand magnitudes; the most-negative value maps onto itself, which is
   // the correct unsigned magnitude.
   always_comb begin
      neg1 = op1_signed(op) && op1[W-1];
      neg2 = op2_signed(op) && op2[W-1];
      mag1 = neg1 ? -op1 : op1;
      mag2 = neg2 ? -op2 : op2;
   end

   // One iteration step.
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shifted = {hi_q, lo_q[W-1]};
      diff    = shifted - {1'b0, b_q};
      ge      = shifted >= {1'b0, b_q};
      if (is_div(op_q)) begin
         hi_n = ge ? diff[W-1:0] : shifted[W-1:0];
         lo_n = {lo_q[W-2:0], ge};
      end else begin
         hi_n = sum[W:1];
         lo_n = {sum[0], lo_q[W-1:1]};
      end
   end

   always_comb begin
      act_d  = act_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      b_d    = b_q;
      if (start) begin
         act_d  = 1'b1;
         cnt_d  = CNT_W'(W - 1);
         op_d   = op;
         qneg_d = neg1 ^ neg2;
         rneg_d = neg1;
         hi_d   = '0;
         if (is_div(op)) begin
            lo_d = mag1;
            b_d  = mag2;
         end else begin
            lo_d = mag2;
            b_d  = mag1;
         end
      end else if (act_q) begin
         hi_d  = hi_n;
         lo_d  = lo_n;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) act_d = 1'b0;
      end
   end

   // Sign fix-up on the value the final step produces.
   always_comb begin
      prod = {hi_n, lo_n};
      if (qneg_q) prod = -prod;
      result = '0;
      case (op_q)
         OP_MUL:                       result = prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*W-1:W];
         OP_DIV, OP_DIVU:              result = qneg_q ? -lo_n : lo_n;
         OP_REM, OP_REMU:              result = rneg_q ? -hi_n : hi_n;
         default:                      result = '0;
      endcase
      done = act_q && (cnt_q == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_q  <= 1'b0;
         cnt_q  <= '0;
         op_q   <= OP_ADD;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
      end else begin
         act_q  <= act_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         b_q    <= b_d;
      end
   end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked RV32IM execute-stage ALU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_muldiv_if slave (request, response, busy, state_dbg)
// Simple ops, illegal opcodes, divide-by-zero and signed overflow finish in
// one cycle (IDLE -> DONE). Other MUL*/DIV*/REM* run DATA_WIDTH cycles in
// alu_muldiv_iter (IDLE -> CALC -> DONE). EQ/LT/LTU are registered at accept.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   alu_muldiv_if.slave bus
);
   localparam int W       = DATA_WIDTH;
   localparam int SHAMT_W = $clog2(DATA_WIDTH);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   alu_state_e   state_q, state_d;
   logic [W-1:0] result_q, result_d;
   logic         eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;

   alu_op_t      op_in;
   logic [W-1:0] a, b;
   logic [SHAMT_W-1:0] shamt;
   logic         div_zero, ovf;
   logic [W-1:0] simple_res;
   logic         iter_start, iter_done;
   logic [W-1:0] iter_result;

   assign op_in = alu_op_t'(bus.ALUctrl);
   assign a     = bus.ALUop1;
   assign b     = bus.ALUop2;
   assign shamt = b[SHAMT_W-1:0];

   // Special divide cases are resolved at accept without iterating.
   assign div_zero = is_div(op_in) && (b == '0);
   assign ovf      = (op_in == OP_DIV || op_in == OP_REM) && (a == MIN_VAL) && (b == '1);

   always_comb begin
      simple_res = {W{ALU_ILLEGAL_RESULT}};
      case (op_in)
         OP_ADD:  simple_res = a + b;
         OP_SUB:  simple_res = a - b;
         OP_XOR:  simple_res = a ^ b;
         OP_OR:   simple_res = a | b;
         OP_AND:  simple_res = a & b;
         OP_SLT:  simple_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: simple_res = {{(W-1){1'b0}}, (a < b)};
         OP_SLL:  simple_res = a << shamt;
         OP_SRL:  simple_res = a >> shamt;
         OP_SRA:  simple_res = $signed(a) >>> shamt;
         // Only selected for divide-by-zero or signed overflow.
         OP_DIV, OP_DIVU: simple_res = div_zero ? '1 : MIN_VAL;
         OP_REM, OP_REMU: simple_res = div_zero ? a : '0;
         default: simple_res = {W{ALU_ILLEGAL_RESULT}};
      endcase
   end

   alu_muldiv_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter (
      .clk   (clk),
      .rst   (rst),
      .start (iter_start),
      .op    (op_in),
      .op1   (a),
      .op2   (b),
      .done  (iter_done),
      .result(iter_result)
   );

   // Next state and datapath updates.
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      eq_d       = eq_q;
      lt_d       = lt_q;
      ltu_d      = ltu_q;
      iter_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               eq_d  = (a == b);
               lt_d  = ($signed(a) < $signed(b));
               ltu_d = (a < b);
               if (is_iter(op_in) && !div_zero && !ovf) begin
                  state_d    = S_CALC;
                  iter_start = 1'b1;
               end else begin
                  state_d  = S_DONE;
                  result_d = simple_res;
               end
            end
         end
         S_CALC: begin
            if (iter_done) begin
               state_d  = S_DONE;
               result_d = iter_result;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_DONE);
      bus.busy      = (state_q != S_IDLE);
      bus.ALUresult = result_q;
      bus.EQ        = eq_q;
      bus.LT        = lt_q;
      bus.LTU       = ltu_q;
      bus.state_dbg = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         ltu_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         ltu_q    <= ltu_d;
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: self-checking bench for alu_muldiv (DATA_WIDTH = 32).
module tb_alu_muldiv;
   import alu_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   alu_muldiv_if #(.DATA_WIDTH(W)) bus ();

   alu_muldiv #(.DATA_WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [34:0] exp_q[$];   // {EQ, LT, LTU, result}
   int          lat_q[$];
   int          acc_q[$];
   bit          seen_v = 1'b0;
   logic [34:0] mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [34:0] model(input logic [4:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
      logic [31:0] r;
      logic [63:0] p;
      r = '0;
      p = '0;
      case (op)
         5'h00: r = x + y;
         5'h01: r = x - y;
         5'h02: r = x ^ y;
         5'h03: r = x | y;
         5'h04: r = x & y;
         5'h05: r = {31'b0, ($signed(x) < $signed(y))};
         5'h06: r = {31'b0, (x < y)};
         5'h07: r = x << y[4:0];
         5'h08: r = x >> y[4:0];
         5'h09: r = $signed(x) >>> y[4:0];
         5'h0A: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
         5'h0B: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
         5'h0C: begin p = {{32{x[31]}}, x} * {32'b0, y}; r = p[63:32]; end
         5'h0D: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
         5'h0E: begin
            if (y == 0) r = 32'hFFFFFFFF;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
            else r = $signed(x) / $signed(y);
         end
         5'h0F: r = (y == 0) ? 32'hFFFFFFFF : x / y;
         5'h10: begin
            if (y == 0) r = x;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h0;
            else r = $signed(x) % $signed(y);
         end
         5'h11: r = (y == 0) ? x : x % y;
         default: r = 32'h0;
      endcase
      return {(x == y), ($signed(x) < $signed(y)), (x < y), r};
   endfunction

   function automatic int exp_lat(input logic [4:0] op, input logic [31:0] x,
                                  input logic [31:0] y);
      bit dz;
      bit ov;
      dz = (op >= 5'h0E && op <= 5'h11) && (y == 0);
      ov = (op == 5'h0E || op == 5'h10) && (x == 32'h80000000) && (y == 32'hFFFFFFFF);
      if (op >= 5'h0A && op <= 5'h11 && !dz && !ov) return W + 1;
      return 1;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUctrl  = op;
      bus.ALUop1   = x;
      bus.ALUop2   = y;
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(op, x, y));
      lat_q.push_back(exp_lat(op, x, y));
      acc_q.push_back(cyc);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         lat_q.delete();
         acc_q.delete();
      end
      @(negedge clk);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         seen_v = 1'b0;
      end else if (bus.out_valid) begin
         if (!seen_v) begin
            seen_v = 1'b1;
            if (lat_q.size() == 0) check("spurious_valid", 32'(bus.out_valid), 32'd0);
            else check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
         end
         if (bus.out_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            check("result", bus.ALUresult, mon_e[31:0]);
            check("eq",  32'(bus.EQ),  32'(mon_e[34]));
            check("lt",  32'(bus.LT),  32'(mon_e[33]));
            check("ltu", 32'(bus.LTU), 32'(mon_e[32]));
            seen_v = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [34:0] bp_e;
   int          bp_wait;

   initial begin
      bus.in_valid  = 1'b0;
      bus.ALUctrl   = '0;
      bus.ALUop1    = '0;
      bus.ALUop2    = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result",    bus.ALUresult,      32'd0);
      check("rst_flags",     32'({bus.EQ, bus.LT, bus.LTU}), 32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_state",     32'(bus.state_dbg), 32'(S_IDLE));

      // Directed operations, issued back to back.
      drive_op(5'h00, 32'd7, 32'd5);
      drive_op(5'h01, 32'd3, 32'd5);
      drive_op(5'h0A, 32'hFFFFFFFF, 32'hFFFFFFFF);
      drive_op(5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF);
      drive_op(5'h0B, 32'h80000000, 32'h80000000);
      drive_op(5'h0C, 32'hFFFFFFFE, 32'h00000003);
      drive_op(5'h0E, 32'hFFFFFFF9, 32'd2);
      drive_op(5'h10, 32'hFFFFFFF9, 32'd2);
      drive_op(5'h0F, 32'd100, 32'd7);
      drive_op(5'h0E, 32'h00000055, 32'd0);
      drive_op(5'h11, 32'h00001234, 32'd0);
      drive_op(5'h0E, 32'h80000000, 32'hFFFFFFFF);
      drive_op(5'h10, 32'h80000000, 32'hFFFFFFFF);
      drive_op(5'h09, 32'h80000010, 32'd4);
      drive_op(5'h07, 32'h00000003, 32'h00000021);
      drive_op(5'h15, 32'h12345678, 32'h9ABCDEF0);
      wait_drain();

      // Backpressure: result held while the consumer stalls.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      drive_op(5'h0F, 32'd100, 32'd7);
      bp_e = model(5'h0F, 32'd100, 32'd7);
      bp_wait = 0;
      while (!bus.out_valid && bp_wait < 100) begin
         @(negedge clk);
         bp_wait++;
      end
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b1;
      bus.ALUctrl  = 5'h00;
      bus.ALUop1   = 32'd1;
      bus.ALUop2   = 32'd2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_result",    bus.ALUresult, bp_e[31:0]);
         check("bp_flags",     32'({bus.EQ, bus.LT, bus.LTU}), 32'(bp_e[34:32]));
         check("bp_in_ready",  32'(bus.in_ready),  32'd0);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready_after",  32'(bus.in_ready),  32'd1);
      check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
      check("bp_queue_empty",     32'(exp_q.size()),  32'd0);

      // Reset in CALC cycle 10 of a MUL aborts it.
      drive_op(5'h0A, 32'h12345678, 32'h9ABCDEF0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_result",    bus.ALUresult,      32'd0);
      check("abort_in_ready",  32'(bus.in_ready),  32'd1);
      check("abort_busy",      32'(bus.busy),      32'd0);
      check("abort_state",     32'(bus.state_dbg), 32'(S_IDLE));
      drive_op(5'h00, 32'd1, 32'd1);
      wait_drain();

      // Random operations including illegal opcodes and corner operands.
      for (int i = 0; i < 24; i++) begin
         logic [4:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 5'($urandom_range(0, 31));
         ra  = $urandom();
         rb  = $urandom();
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'hFFFFFFFF;
            2: ra = 32'h80000000;
            3: rb = ra;
            default: ;
         endcase
         drive_op(rop, ra, rb);
      end
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
